// File: rtl/wb_pkg.sv
`default_nettype none
// =============================================================================
// wb_pkg : shared types and default widths for the ALU write-back stage
// Revision : 1.0
// =============================================================================
package wb_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_DEPTH       = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_REL  = 2'd2
  } out_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// =============================================================================
// wb_fifo : DEPTH-entry circular FIFO exposing both the head and newest entry
// Revision : 1.0
// =============================================================================
module wb_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] newest
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q;
  logic [PTR_W:0]   rd_ptr_d;
  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] newest_idx;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign newest_idx = wr_ptr_q[PTR_W-1:0] - PTR_W'(1);
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign newest     = mem_q[newest_idx];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// =============================================================================
// alu_wb_stage : four-phase ALU-result intake, FIFO buffer, RF write-back, bypass
// Revision : 1.0
// =============================================================================
module alu_wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_req,
  output logic              in_ack,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              rf_req,
  input  logic              rf_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              busy,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] req_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_d;
  logic                   req_s;
  logic                   ack_s;

  in_state_t              in_state_q;
  in_state_t              in_state_d;
  logic                   in_ack_q;
  logic                   in_ack_d;

  out_state_t             out_state_q;
  out_state_t             out_state_d;
  logic                   rf_req_q;
  logic                   rf_req_d;
  logic                   rf_we_q;
  logic                   rf_we_d;
  logic [ADDR_W-1:0]      rf_addr_q;
  logic [ADDR_W-1:0]      rf_addr_d;
  logic [DATA_W-1:0]      rf_data_q;
  logic [DATA_W-1:0]      rf_data_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [ENTRY_W-1:0]     fifo_head;
  logic [ENTRY_W-1:0]     fifo_newest;

  always_comb begin
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], in_req};
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], rf_ack};
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Intake: a request with in_we=0 is still acknowledged but nothing is stored.
  always_comb begin
    in_state_d = in_state_q;
    in_ack_d   = in_ack_q;
    fifo_push  = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (req_s && !fifo_full) begin
          fifo_push  = in_we;
          in_ack_d   = 1'b1;
          in_state_d = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!req_s) begin
          in_ack_d   = 1'b0;
          in_state_d = IN_IDLE;
        end
      end
      default: begin
        in_ack_d   = 1'b0;
        in_state_d = IN_IDLE;
      end
    endcase
  end

  always_comb begin
    out_state_d = out_state_q;
    rf_req_d    = rf_req_q;
    rf_we_d     = rf_we_q;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (!fifo_empty) begin
          {rf_addr_d, rf_data_d} = fifo_head;
          rf_we_d                = 1'b1;
          rf_req_d               = 1'b1;
          out_state_d            = OUT_REQ;
        end
      end
      // The entry stays in the FIFO (and visible on the bypass) until the RF acks.
      OUT_REQ: begin
        if (ack_s) begin
          rf_req_d    = 1'b0;
          fifo_pop    = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          out_state_d = OUT_REL;
        end
      end
      OUT_REL: begin
        if (!ack_s) begin
          rf_we_d     = 1'b0;
          out_state_d = OUT_IDLE;
        end
      end
      default: begin
        rf_req_d    = 1'b0;
        rf_we_d     = 1'b0;
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_sync_q  <= '0;
      ack_sync_q  <= '0;
      in_state_q  <= IN_IDLE;
      in_ack_q    <= 1'b0;
      out_state_q <= OUT_IDLE;
      rf_req_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      cnt_q       <= '0;
    end else begin
      req_sync_q  <= req_sync_d;
      ack_sync_q  <= ack_sync_d;
      in_state_q  <= in_state_d;
      in_ack_q    <= in_ack_d;
      out_state_q <= out_state_d;
      rf_req_q    <= rf_req_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      cnt_q       <= cnt_d;
    end
  end

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({in_addr, in_data}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .newest  (fifo_newest)
  );

  assign in_ack                 = in_ack_q;
  assign rf_req                 = rf_req_q;
  assign rf_we                  = rf_we_q;
  assign rf_addr                = rf_addr_q;
  assign rf_data                = rf_data_q;
  assign retired_count          = cnt_q;
  assign fwd_valid              = !fifo_empty;
  assign {fwd_addr, fwd_data}   = fifo_newest;
  assign busy                   = !fifo_empty || (in_state_q != IN_IDLE) ||
                                  (out_state_q != OUT_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// Bench for alu_wb_stage: directed handshake scenarios, then randomized batches
// whose retire order, bypass and count are predicted by a queue model.
module tb_alu_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_req;
  logic        in_ack;
  logic        in_we;
  logic [3:0]  in_addr;
  logic [15:0] in_data;
  logic        rf_req;
  logic        rf_ack;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic        busy;
  logic [15:0] retired_count;

  int          checks = 0;
  int          errors = 0;
  wb_entry_t   model_q[$];
  logic [15:0] exp_cnt;
  logic        bwe   [6];
  logic [3:0]  baddr [6];
  logic [15:0] bdata [6];
  int          nw;
  logic        seen;

  always #5 clk = ~clk;

  alu_wb_stage #(
    .DATA_W      (16),
    .ADDR_W      (4),
    .DEPTH       (2),
    .SYNC_STAGES (2),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_req        (in_req),
    .in_ack        (in_ack),
    .in_we         (in_we),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .rf_req        (rf_req),
    .rf_ack        (rf_ack),
    .rf_we         (rf_we),
    .rf_addr       (rf_addr),
    .rf_data       (rf_data),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .busy          (busy),
    .retired_count (retired_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ack"},  32'(in_ack),        0);
    check({tag, "_rf_req"},  32'(rf_req),        0);
    check({tag, "_rf_we"},   32'(rf_we),         0);
    check({tag, "_rf_addr"}, 32'(rf_addr),       0);
    check({tag, "_rf_data"}, 32'(rf_data),       0);
    check({tag, "_fwd_v"},   32'(fwd_valid),     0);
    check({tag, "_fwd_a"},   32'(fwd_addr),      0);
    check({tag, "_fwd_d"},   32'(fwd_data),      0);
    check({tag, "_busy"},    32'(busy),          0);
    check({tag, "_count"},   32'(retired_count), 0);
  endtask

  task automatic wait_in_ack(input logic val, input string tag);
    for (int i = 0; i < 400 && in_ack !== val; i++) @(negedge clk);
    check(tag, 32'(in_ack), 32'(val));
  endtask

  task automatic wait_rf_req(input logic val, input string tag);
    for (int i = 0; i < 400 && rf_req !== val; i++) @(negedge clk);
    check(tag, 32'(rf_req), 32'(val));
  endtask

  task automatic model_push(input logic [3:0] a, input logic [15:0] d);
    wb_entry_t e;
    e.addr = a;
    e.data = d;
    model_q.push_back(e);
  endtask

  task automatic alu_send(input logic we, input logic [3:0] a, input logic [15:0] d);
    in_we   = we;
    in_addr = a;
    in_data = d;
    in_req  = 1'b1;
    wait_in_ack(1'b1, "alu_ack_rise");
    if (we) model_push(a, d);
    in_req = 1'b0;
    wait_in_ack(1'b0, "alu_ack_fall");
  endtask

  // Complete one RF write: the presented entry must be the oldest unretired one.
  task automatic rf_serve(input string tag);
    wb_entry_t e;
    wait_rf_req(1'b1, {tag, "_req_rise"});
    e = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, "_we"},   32'(rf_we),   1);
    check({tag, "_addr"}, 32'(rf_addr), 32'(e.addr));
    check({tag, "_data"}, 32'(rf_data), 32'(e.data));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rf_ack = 1'b1;
    wait_rf_req(1'b0, {tag, "_req_fall"});
    if (model_q.size() > 0) void'(model_q.pop_front());
    exp_cnt = exp_cnt + 16'd1;
    check({tag, "_count"}, 32'(retired_count), 32'(exp_cnt));
    rf_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    in_req  = 1'b0;
    in_we   = 1'b0;
    in_addr = '0;
    in_data = '0;
    rf_ack  = 1'b0;
    exp_cnt = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: ack two edges after sampling, RF request one edge later
    in_we = 1'b1; in_addr = 4'd3; in_data = 16'h1234; in_req = 1'b1;
    @(negedge clk); check("lat_ack_e1", 32'(in_ack), 0);
    @(negedge clk); check("lat_ack_e2", 32'(in_ack), 0);
    @(negedge clk); check("lat_ack_e3", 32'(in_ack), 1);
    check("lat_rfreq_e3", 32'(rf_req), 0);
    model_push(4'd3, 16'h1234);
    @(negedge clk); check("lat_rfreq_e4", 32'(rf_req), 1);
    check("lat_rf_addr", 32'(rf_addr), 3);
    check("lat_rf_data", 32'(rf_data), 32'h1234);
    in_req = 1'b0;
    wait_in_ack(1'b0, "single_ack_fall");
    rf_serve("single");
    check("single_count", 32'(retired_count), 1);

    // Discarded transfer (in_we=0)
    alu_send(1'b0, 4'd5, 16'hBEEF);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rf_req | fwd_valid;
    end
    check("we0_no_activity", 32'(seen), 0);
    check("we0_count", 32'(retired_count), 1);

    // Backpressure: RF stalled, third write must wait for a free slot
    alu_send(1'b1, 4'd1, 16'h1111);
    alu_send(1'b1, 4'd2, 16'h2222);
    in_we = 1'b1; in_addr = 4'd3; in_data = 16'h3333; in_req = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_blocked", 32'(in_ack), 0);
    check("bp_fwd_addr", 32'(fwd_addr), 2);
    check("bp_busy", 32'(busy), 1);
    rf_serve("bp1");
    wait_in_ack(1'b1, "bp_third_ack");
    model_push(4'd3, 16'h3333);
    in_req = 1'b0;
    wait_in_ack(1'b0, "bp_third_fall");
    rf_serve("bp2");
    rf_serve("bp3");

    // Bypass shows the newest entry
    alu_send(1'b1, 4'd7, 16'h00AA);
    alu_send(1'b1, 4'd8, 16'h0055);
    check("byp_valid", 32'(fwd_valid), 1);
    check("byp_addr", 32'(fwd_addr), 8);
    check("byp_data", 32'(fwd_data), 32'h0055);
    rf_serve("byp1");
    check("byp_after1_addr", 32'(fwd_addr), 8);
    rf_serve("byp2");
    check("byp_empty", 32'(fwd_valid), 0);

    // Simultaneous push and pop with one entry held
    alu_send(1'b1, 4'd9, 16'h0909);
    wait_rf_req(1'b1, "sim_req_up");
    @(negedge clk);
    in_we = 1'b1; in_addr = 4'd10; in_data = 16'h0A0A; in_req = 1'b1;
    rf_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sim_pre_ack", 32'(in_ack), 0);
    check("sim_pre_req", 32'(rf_req), 1);
    @(negedge clk);
    void'(model_q.pop_front());
    exp_cnt = exp_cnt + 16'd1;
    model_push(4'd10, 16'h0A0A);
    check("sim_ack", 32'(in_ack), 1);
    check("sim_req_low", 32'(rf_req), 0);
    check("sim_count", 32'(retired_count), 32'(exp_cnt));
    check("sim_fwd_valid", 32'(fwd_valid), 1);
    check("sim_fwd_addr", 32'(fwd_addr), 10);
    check("sim_fwd_data", 32'(fwd_data), 32'h0A0A);
    in_req = 1'b0;
    rf_ack = 1'b0;
    wait_in_ack(1'b0, "sim_ack_fall");
    rf_serve("sim_next");
    check("sim_empty", 32'(fwd_valid), 0);

    // Reset mid-transfer
    alu_send(1'b1, 4'd4, 16'h4444);
    wait_rf_req(1'b1, "rst_rf_up");
    in_we = 1'b1; in_addr = 4'd6; in_data = 16'h6666; in_req = 1'b1;
    wait_in_ack(1'b1, "rst_in_up");
    check("rst_pre_rfreq", 32'(rf_req), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    in_req = 1'b0;
    model_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    alu_send(1'b1, 4'd12, 16'hCAFE);
    rf_serve("post_rst");
    check("post_rst_count", 32'(retired_count), 1);

    // Randomized batches: ALU and RF sides run concurrently
    for (int b = 0; b < 10; b++) begin
      nw = 0;
      for (int i = 0; i < 6; i++) begin
        bwe[i]   = ($urandom_range(0, 3) != 0);
        baddr[i] = 4'($urandom);
        bdata[i] = 16'($urandom);
        if (bwe[i]) nw++;
      end
      fork
        begin
          for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            alu_send(bwe[i], baddr[i], bdata[i]);
          end
        end
        begin
          for (int j = 0; j < nw; j++) rf_serve("rand");
        end
      join
      repeat (6) @(negedge clk);
      check("rand_idle_busy", 32'(busy), 0);
      check("rand_idle_fwd", 32'(fwd_valid), 0);
      check("rand_model_empty", 32'(model_q.size()), 0);
      check("rand_count", 32'(retired_count), 32'(exp_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
